// File: rtl/dmem_access_unit.sv
// MEM-stage data-memory access unit: turns EX/MEM loads/stores into a req/ack transaction and stalls the pipe.
// Optional statistics counters are enabled by defining DMEM_STATS_EN.
module dmem_access_unit #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              MemRead_i,
    input  logic              MemWrite_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              stall_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              rdata_valid_o,
    output logic              err_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic [31:0]       stat_access_o,
    output logic [31:0]       stat_stall_o
);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

    // Counter holds the number of WAIT cycles already spent, so the abort fires on the TIMEOUT-th one.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    state_t            state, state_next;
    logic              req, misaligned, accept, ack_done, timeout_hit;
    logic [7:0]        wait_cnt;
    logic              we_q, err_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, rdata_q;

    always_comb begin
        state_next    = state;
        stall_o       = 1'b0;
        err_o         = 1'b0;
        rdata_valid_o = 1'b0;
        accept        = 1'b0;
        ack_done      = 1'b0;
        timeout_hit   = 1'b0;
        misaligned    = 1'b0;
        req           = MemRead_i | MemWrite_i;
        case (state)
            ST_IDLE: begin
                if (req) begin
                    if (addr_i[1:0] != 2'b00) begin
                        misaligned = 1'b1;
                        err_o      = 1'b1;
                    end else begin
                        accept     = 1'b1;
                        stall_o    = 1'b1;
                        state_next = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                stall_o = 1'b1;
                if (mem_ack_i) begin
                    ack_done   = 1'b1;
                    state_next = ST_DONE;
                end else if (wait_cnt == TIMEOUT_LAST) begin
                    timeout_hit = 1'b1;
                    state_next  = ST_DONE;
                end
            end
            ST_DONE: begin
                err_o         = err_q;
                rdata_valid_o = ~we_q & ~err_q;
                state_next    = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign rdata_o     = misaligned ? '0 : rdata_q;
    assign mem_req_o   = (state == ST_WAIT);
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
            we_q     <= 1'b0;
            err_q    <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                we_q     <= MemWrite_i;
                addr_q   <= {addr_i[ADDR_W-1:2], 2'b00};
                wdata_q  <= wdata_i;
                wait_cnt <= '0;
                err_q    <= 1'b0;
            end
            if (state == ST_WAIT) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
            if (ack_done && !we_q) begin
                rdata_q <= mem_rdata_i;
            end
            if (timeout_hit) begin
                err_q <= 1'b1;
                if (!we_q) begin
                    rdata_q <= '0;
                end
            end
        end
    end

`ifdef DMEM_STATS_EN
    logic [31:0] stat_access_q, stat_stall_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stat_access_q <= '0;
            stat_stall_q  <= '0;
        end else begin
            if (ack_done) begin
                stat_access_q <= stat_access_q + 32'd1;
            end
            if (stall_o) begin
                stat_stall_q <= stat_stall_q + 32'd1;
            end
        end
    end

    assign stat_access_o = stat_access_q;
    assign stat_stall_o  = stat_stall_q;
`else
    assign stat_access_o = '0;
    assign stat_stall_o  = '0;
`endif

endmodule
